uart_tx_ctrl: RTL and testbench

//  Sequencer for the UART transmit path. Drives the baud-rate divider and the
//  bit counter, and serialises one byte per frame onto txd: start, data LSB

---
 rtl/uart_tx_ctrl.sv | 114 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, LSB-first data, optional parity, stop bit(s) on a registered txd.
// txd/busy follow the accept edge by one clk; in_ready is high only in IDLE or the final stop cycle, so frames can run back-to-back.
module uart_tx_ctrl #(
  parameter int CLK_DIV   = 25,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [DW-1:0]          div_q;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   par_q;
  logic                   tick;
  logic                   last_data;
  logic                   last_stop;
  logic                   xfer;

  assign tick      = (div_q == DW'(CLK_DIV - 1));
  assign last_data = (bit_q == BW'(DATA_BITS - 1));
  assign last_stop = (bit_q == BW'(STOP_BITS - 1));
  assign in_ready  = !rst && ((state_q == S_IDLE) ||
                              ((state_q == S_STOP) && last_stop && tick));
  assign xfer      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (xfer) state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA:   if (tick && last_data) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick && last_stop) state_d = xfer ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divider restarts on every accept so the new start bit gets a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      if (xfer) begin
        div_q <= '0;
      end else if (state_q != S_IDLE) begin
        div_q <= tick ? '0 : div_q + DW'(1);
      end

      if (tick) begin
        case (state_q)
          S_DATA:  bit_q <= last_data ? '0 : bit_q + BW'(1);
          S_STOP:  bit_q <= last_stop ? '0 : bit_q + BW'(1);
          default: bit_q <= '0;
        endcase
      end

      if (xfer) begin
        shreg_q <= in_data;
        par_q   <= (^in_data) ^ (PARITY == 2);
      end else if ((state_q == S_DATA) && tick) begin
        shreg_q <= {1'b0, shreg_q[DATA_BITS-1:1]};
      end
    end
  end

  // Line driver works from the current state, hence the one-cycle lag behind accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      txd  <= 1'b1;
      busy <= 1'b0;
    end else begin
      case (state_q)
        S_START:  txd <= 1'b0;
        S_DATA:   txd <= shreg_q[0];
        S_PARITY: txd <= par_q;
        default:  txd <= 1'b1;
      endcase
      busy <= (state_q != S_IDLE) && (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: five configurations driven in parallel, checked against a per-cycle line timeline and a UART receiver.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  localparam int NI = 5;
  localparam int QD = 512;

  typedef struct packed {
    logic txd;
    logic busy;
  } line_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] din  [NI];
  logic       vld  [NI];
  logic       rdy  [NI];
  logic       txd  [NI];
  logic       busy [NI];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .in_data(din[0][7:0]), .in_valid(vld[0]), .in_ready(rdy[0]), .txd(txd[0]), .busy(busy[0]));
  uart_tx_ctrl #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .in_data(din[1][7:0]), .in_valid(vld[1]), .in_ready(rdy[1]), .txd(txd[1]), .busy(busy[1]));
  uart_tx_ctrl #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .in_data(din[2][7:0]), .in_valid(vld[2]), .in_ready(rdy[2]), .txd(txd[2]), .busy(busy[2]));
  uart_tx_ctrl #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .in_data(din[3][7:0]), .in_valid(vld[3]), .in_ready(rdy[3]), .txd(txd[3]), .busy(busy[3]));
  uart_tx_ctrl #(.CLK_DIV(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u4 (
    .clk(clk), .rst(rst), .in_data(din[4][4:0]), .in_valid(vld[4]), .in_ready(rdy[4]), .txd(txd[4]), .busy(busy[4]));

  function automatic int cdiv(int i);  return (i == 4) ? 2 : 4; endfunction
  function automatic int dbits(int i); return (i == 4) ? 5 : 8; endfunction
  function automatic int pmode(int i); return (i == 1 || i == 3) ? 1 : (i == 2) ? 2 : 0; endfunction
  function automatic int sbits(int i); return (i == 3) ? 2 : 1; endfunction

  function automatic logic par_of(int i, logic [8:0] d);
    logic p = (pmode(i) == 2);
    for (int k = 0; k < dbits(i); k++) p ^= d[k];
    return p;
  endfunction

  int n_assert = 0;
  int n_fail   = 0;
  bit hold;

  line_t      lq  [NI][QD];
  int         lq_h [NI], lq_n [NI];
  logic [8:0] sb  [NI][64];
  int         sb_h [NI], sb_n [NI];
  logic [8:0] src [NI][64];
  int         src_h [NI], src_n [NI];
  int         xfers [NI];
  bit         rx_on [NI];
  int         rx_t  [NI];
  logic [8:0] rx_b  [NI];

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h at %0t", tag, inst, obs, exp, $time);
    end
  endtask

  task automatic lq_push(input int i, input logic t, input logic b);
    line_t e;
    e.txd  = t;
    e.busy = b;
    lq[i][(lq_h[i] + lq_n[i]) % QD] = e;
    lq_n[i]++;
  endtask

  // Expected line levels, one entry per clk, starting the cycle after the accept edge.
  task automatic push_frame(input int i, input logic [8:0] d);
    int   nb = 1 + dbits(i) + ((pmode(i) != 0) ? 1 : 0) + sbits(i);
    logic lvl;
    if (lq_n[i] == 0) lq_push(i, 1'b1, 1'b0);
    for (int b = 0; b < nb; b++) begin
      if (b == 0) lvl = 1'b0;
      else if (b <= dbits(i)) lvl = d[b-1];
      else if (pmode(i) != 0 && b == dbits(i) + 1) lvl = par_of(i, d);
      else lvl = 1'b1;
      repeat (cdiv(i)) lq_push(i, lvl, 1'b1);
    end
    sb[i][(sb_h[i] + sb_n[i]) % 64] = d;
    sb_n[i]++;
  endtask

  task automatic enqueue(input int i, input logic [8:0] d);
    src[i][(src_h[i] + src_n[i]) % 64] = d & 9'((1 << dbits(i)) - 1);
    src_n[i]++;
  endtask

  task automatic rx_step(input int i);
    int c = cdiv(i);
    int bn;
    if (!rx_on[i]) begin
      if (txd[i] === 1'b0) begin
        rx_on[i] = 1'b1;
        rx_t[i]  = 0;
        rx_b[i]  = '0;
      end
    end else begin
      rx_t[i]++;
      if (rx_t[i] % c == c / 2) begin
        bn = rx_t[i] / c;
        if (bn == 0) chk("rx_start", i, txd[i], 1'b0);
        else if (bn <= dbits(i)) rx_b[i][bn-1] = txd[i];
        else if (pmode(i) != 0 && bn == dbits(i) + 1) begin
          if (sb_n[i] > 0) chk("rx_parity", i, txd[i], par_of(i, sb[i][sb_h[i]]));
        end else begin
          chk("rx_stop", i, txd[i], 1'b1);
          chk("rx_pending", i, sb_n[i] > 0, 1'b1);
          if (sb_n[i] > 0) begin
            chk("rx_byte", i, rx_b[i], sb[i][sb_h[i]]);
            sb_h[i] = (sb_h[i] + 1) % 64;
            sb_n[i]--;
          end
          rx_on[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle(input logic rst_v);
    line_t e;
    logic  exp_rdy;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      e.txd  = 1'b1;
      e.busy = 1'b0;
      if (lq_n[i] > 0) begin
        e       = lq[i][lq_h[i]];
        lq_h[i] = (lq_h[i] + 1) % QD;
        lq_n[i]--;
      end
      chk("txd", i, txd[i], e.txd);
      chk("busy", i, busy[i], e.busy && (lq_n[i] > 0));
      rx_step(i);
    end
    rst = rst_v;
    for (int i = 0; i < NI; i++) begin
      if (src_n[i] > 0 && (hold || $urandom_range(0, 3) != 0)) begin
        vld[i] = 1'b1;
        din[i] = src[i][src_h[i]];
      end else begin
        vld[i] = 1'b0;
        din[i] = 9'($urandom);
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_rdy = !rst_v && (lq_n[i] <= 1);
      chk("in_ready", i, rdy[i], exp_rdy);
      if (vld[i] && exp_rdy) begin
        push_frame(i, din[i]);
        src_h[i] = (src_h[i] + 1) % 64;
        src_n[i]--;
        xfers[i]++;
      end
    end
    if (rst_v) begin
      for (int i = 0; i < NI; i++) begin
        lq_n[i]  = 0;
        sb_n[i]  = 0;
        rx_on[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    int pend;
    do begin
      pend = 0;
      for (int i = 0; i < NI; i++) pend += src_n[i] + lq_n[i];
      if (pend != 0) begin
        cycle(1'b0);
        n++;
      end
    end while (pend != 0 && n < bound);
    chk("drain", 0, pend, 0);
  endtask

  initial begin
    hold = 1'b1;
    rst  = 1'b1;
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0; din[i] = '0;
      lq_h[i] = 0; lq_n[i] = 0; sb_h[i] = 0; sb_n[i] = 0;
      src_h[i] = 0; src_n[i] = 0; xfers[i] = 0;
      rx_on[i] = 1'b0; rx_t[i] = 0; rx_b[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_ready", i, rdy[i], 1'b0);
      chk("rst_txd", i, txd[i], 1'b1);
      chk("rst_busy", i, busy[i], 1'b0);
    end

    repeat (20) cycle(1'b0);
    for (int i = 0; i < NI; i++) chk("idle_xfers", i, xfers[i], 0);

    for (int i = 0; i < NI; i++) enqueue(i, 9'h55);
    wait_idle(200);

    for (int i = 0; i < NI; i++) begin
      xfers[i] = 0;
      enqueue(i, 9'h00);
      enqueue(i, 9'hFF);
    end
    wait_idle(300);
    for (int i = 0; i < NI; i++) chk("b2b_xfers", i, xfers[i], 2);

    for (int i = 0; i < NI; i++) enqueue(i, 9'h07);
    wait_idle(200);

    // Abort 0xA5 mid data bit 3 of instance 0, then send a clean frame.
    for (int i = 0; i < NI; i++) begin
      xfers[i] = 0;
      enqueue(i, 9'hA5);
    end
    for (int n = 0; n < 50 && xfers[0] == 0; n++) cycle(1'b0);
    chk("abort_accepted", 0, xfers[0], 1);
    repeat (17) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    chk("abort_txd", 0, txd[0], 1'b1);
    chk("abort_busy", 0, busy[0], 1'b0);
    for (int i = 0; i < NI; i++) enqueue(i, 9'h3C);
    wait_idle(200);

    for (int i = 0; i < NI; i++) enqueue(i, 9'h1F);
    wait_idle(200);

    hold = 1'b0;
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 25; k++) enqueue(i, 9'($urandom));
    end
    wait_idle(5000);
    repeat (4) cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
